// File: rtl/d_axi_master.sv
// d_axi_master
// ---------------------------------------------------------------------------
// Memory-side bridge for the L1 data cache. Converts the cache's D interface
// into AXI4 master transactions:
//   - read miss    -> one BURST_BEATS-beat INCR read burst
//   - write-through -> one single-beat AXI write (AW + W + B)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   D_req_read               read request, held by the cache until last beat
//   D_addr / D_in / D_strb   address, write data, active-low byte enables
//                            (D_strb == 4'hF means "no write")
//   D_out                    read beat data, valid while D_wait is low
//   D_wait                   low for one cycle per completed beat / write
//   AR*/R*/AW*/W*/B*         AXI4 master channels
//   state_dbg, beat_cnt_dbg  FSM state and beat counter for observation
//
// Optional build macro D_AXI_PERF_EN adds perf_rd_bursts, perf_wr_cnt,
// perf_stall_cyc (saturating) and err_sticky.
//
// Handshake rule: a transfer happens on a rising clk edge where VALID and
// READY are both high; VALID and its payload stay stable until that edge.
// ---------------------------------------------------------------------------
module d_axi_master #(
    parameter  int              ID_W        = 4,
    parameter  logic [ID_W-1:0] MST_ID      = ID_W'(1),
    parameter  int              BURST_BEATS = 4,
    localparam int              CNT_W       = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D_req_read,
    input  logic [31:0]      D_addr,
    input  logic [31:0]      D_in,
    input  logic [3:0]       D_strb,
    output logic [31:0]      D_out,
    output logic             D_wait,
    output logic [ID_W-1:0]  ARID,
    output logic [31:0]      ARADDR,
    output logic [3:0]       ARLEN,
    output logic [2:0]       ARSIZE,
    output logic [1:0]       ARBURST,
    output logic             ARVALID,
    input  logic             ARREADY,
    input  logic [ID_W-1:0]  RID,
    input  logic [31:0]      RDATA,
    input  logic [1:0]       RRESP,
    input  logic             RLAST,
    input  logic             RVALID,
    output logic             RREADY,
    output logic [ID_W-1:0]  AWID,
    output logic [31:0]      AWADDR,
    output logic [3:0]       AWLEN,
    output logic [2:0]       AWSIZE,
    output logic [1:0]       AWBURST,
    output logic             AWVALID,
    input  logic             AWREADY,
    output logic [31:0]      WDATA,
    output logic [3:0]       WSTRB,
    output logic             WLAST,
    output logic             WVALID,
    input  logic             WREADY,
    input  logic [ID_W-1:0]  BID,
    input  logic [1:0]       BRESP,
    input  logic             BVALID,
    output logic             BREADY,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] beat_cnt_dbg
`ifdef D_AXI_PERF_EN
    ,
    output logic [31:0]      perf_rd_bursts,
    output logic [31:0]      perf_wr_cnt,
    output logic [31:0]      perf_stall_cyc,
    output logic             err_sticky
`endif
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] AR   = 3'd1;
    localparam logic [2:0] R    = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] B    = 3'd4;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);
    localparam logic [1:0]       INCR      = 2'b01;

    logic [2:0]       state;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic [3:0]       strb_q;
    logic [CNT_W-1:0] beat_cnt;
    logic             aw_done;
    logic             w_done;

    logic r_beat;   // read beat transferred this cycle
    logic b_done;   // write response accepted this cycle
    logic last_beat;

    assign r_beat    = (state == R) && RVALID;
    assign b_done    = (state == B) && BVALID;
    assign last_beat = (beat_cnt == LAST_BEAT);

    // Address / data channels are driven only from captured registers.
    assign ARID    = MST_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = 4'(BURST_BEATS - 1);
    assign ARSIZE  = 3'b010;
    assign ARBURST = INCR;
    assign ARVALID = (state == AR);
    assign RREADY  = (state == R);

    assign AWID    = MST_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = INCR;
    assign AWVALID = (state == WR) && !aw_done;
    assign WDATA   = data_q;
    assign WSTRB   = ~strb_q;
    assign WLAST   = 1'b1;
    assign WVALID  = (state == WR) && !w_done;
    assign BREADY  = (state == B);

    // Read data passes straight through so the cache sees it in the beat cycle.
    assign D_out  = r_beat ? RDATA : 32'h0;
    assign D_wait = !(r_beat || b_done);

    assign state_dbg    = state;
    assign beat_cnt_dbg = beat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
            strb_q   <= 4'h0;
            beat_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    addr_q  <= D_addr;
                    data_q  <= D_in;
                    strb_q  <= D_strb;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (D_req_read)
                        state <= AR;
                    else if (D_strb != 4'hF)
                        state <= WR;
                end
                AR: begin
                    if (ARREADY) begin
                        state    <= R;
                        beat_cnt <= '0;
                    end
                end
                R: begin
                    // Burst end is decided by the beat count; RLAST is ignored.
                    if (RVALID) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                WR: begin
                    if (AWVALID && AWREADY) aw_done <= 1'b1;
                    if (WVALID && WREADY)   w_done  <= 1'b1;
                    // Both flags are registered, so B is entered the cycle
                    // after the later of the two handshakes.
                    if (aw_done && w_done) state <= B;
                end
                B: begin
                    if (BVALID) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef D_AXI_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_bursts <= 32'h0;
            perf_wr_cnt    <= 32'h0;
            perf_stall_cyc <= 32'h0;
            err_sticky     <= 1'b0;
        end else begin
            if (r_beat && last_beat && perf_rd_bursts != 32'hFFFF_FFFF)
                perf_rd_bursts <= perf_rd_bursts + 32'd1;
            if (b_done && perf_wr_cnt != 32'hFFFF_FFFF)
                perf_wr_cnt <= perf_wr_cnt + 32'd1;
            if (state != IDLE && D_wait && perf_stall_cyc != 32'hFFFF_FFFF)
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if ((r_beat && (RRESP != 2'b00 || RLAST != last_beat)) ||
                (b_done && BRESP != 2'b00))
                err_sticky <= 1'b1;
        end
    end
`endif

    // Response IDs are not checked: one master ID, in-order responses.
    logic unused_inputs;
    assign unused_inputs = ^{RID, BID, RRESP, BRESP, RLAST};

endmodule
